// File: rtl/zx_tape_loader_pkg.sv
// Shared types and constants for the ZX tape-style screen loader.
package zx_tape_loader_pkg;

  localparam int unsigned BYTE_W           = 8;
  localparam int unsigned BORDER_W         = 3;

  localparam int unsigned DEF_NUM_BYTES    = 6912;
  localparam int unsigned DEF_ADDR_W       = 13;
  localparam int unsigned DEF_HALF_ZERO    = 855;
  localparam int unsigned DEF_HALF_ONE     = 1710;
  localparam int unsigned DEF_PILOT_HALF   = 2168;
  localparam int unsigned DEF_PILOT_PULSES = 64;
  localparam int unsigned DEF_SYNC_HALF    = 700;

  localparam logic [BORDER_W-1:0] BORDER_IDLE     = 3'd0;
  localparam logic [BORDER_W-1:0] BORDER_PILOT_LO = 3'd2;
  localparam logic [BORDER_W-1:0] BORDER_PILOT_HI = 3'd5;
  localparam logic [BORDER_W-1:0] BORDER_BIT_LO   = 3'd1;
  localparam logic [BORDER_W-1:0] BORDER_BIT_HI   = 3'd6;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_PILOT,
    ST_SYNC,
    ST_FETCH,
    ST_LATCH,
    ST_BIT_LO,
    ST_BIT_HI,
    ST_WRITE,
    ST_DONE
  } state_e;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  // Bits needed to count 0..n-1, never less than one.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tape_halfperiod_timer.sv
// Half-period timer: counts 0..last, pulses tc_c on the final count, then wraps.
module tape_halfperiod_timer #(
  parameter int unsigned CNT_W = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic [CNT_W-1:0] last,
  output logic             tc_c
);

  logic [CNT_W-1:0] cnt;

  assign tc_c = (cnt == last);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr || tc_c) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/zx_tape_loader.sv
// Tape-style screen load sequencer: replays each ROM byte as timed ear pulses, then writes it.
// Define TAPE_PILOT_EN to include the pilot tone and sync pulses ahead of the data.
module zx_tape_loader
  import zx_tape_loader_pkg::*;
#(
  parameter int unsigned NUM_BYTES = DEF_NUM_BYTES,
  parameter int unsigned ADDR_W    = DEF_ADDR_W,
  parameter int unsigned HALF_ZERO = DEF_HALF_ZERO,
  parameter int unsigned HALF_ONE  = DEF_HALF_ONE
`ifdef TAPE_PILOT_EN
  ,
  parameter int unsigned PILOT_HALF   = DEF_PILOT_HALF,
  parameter int unsigned PILOT_PULSES = DEF_PILOT_PULSES,
  parameter int unsigned SYNC_HALF    = DEF_SYNC_HALF
`endif
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                skip,
  output logic [ADDR_W-1:0]   src_addr,
  input  logic [BYTE_W-1:0]   src_data,
  output logic                wr_en,
  output logic [ADDR_W-1:0]   wr_addr,
  output logic [BYTE_W-1:0]   wr_data,
  output logic [ADDR_W-1:0]   progress,
  output logic                busy,
  output logic                done,
  output logic                ear,
  output logic [BORDER_W-1:0] border
);

`ifdef TAPE_PILOT_EN
  localparam int unsigned MAX_HALF = max_u(max_u(HALF_ZERO, HALF_ONE),
                                           max_u(PILOT_HALF, SYNC_HALF));
  localparam int unsigned PCNT_W   = cnt_width(PILOT_PULSES);
  localparam state_e      FIRST_ST = ST_PILOT;
`else
  localparam int unsigned MAX_HALF = max_u(HALF_ZERO, HALF_ONE);
  localparam state_e      FIRST_ST = ST_FETCH;
`endif
  localparam int unsigned CNT_W    = cnt_width(MAX_HALF);
  localparam int unsigned BITC_W   = 3;

  state_e                state, state_nxt;
  logic [ADDR_W-1:0]     byte_idx, byte_idx_nxt;
  logic [BYTE_W-1:0]     shreg, shreg_nxt;
  logic [BYTE_W-1:0]     orig_q, orig_nxt;
  logic [BITC_W-1:0]     bit_cnt, bit_cnt_nxt;
`ifdef TAPE_PILOT_EN
  logic [PCNT_W-1:0]     pilot_cnt, pilot_cnt_nxt;
`endif

  logic [ADDR_W-1:0]     src_addr_nxt;
  logic                  wr_en_nxt;
  logic [ADDR_W-1:0]     wr_addr_nxt;
  logic [BYTE_W-1:0]     wr_data_nxt;
  logic [ADDR_W-1:0]     progress_nxt;
  logic                  busy_nxt;
  logic                  done_nxt;
  logic                  ear_nxt;
  logic [BORDER_W-1:0]   border_nxt;

  logic [CNT_W-1:0]      tmr_last_c;
  logic                  tmr_clr_c;
  logic                  tmr_tc_c;

  tape_halfperiod_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (tmr_clr_c),
    .last  (tmr_last_c),
    .tc_c  (tmr_tc_c)
  );

  // Half-period length for the current state; data bits follow the MSB about to be sent.
  always_comb begin
    tmr_last_c = '0;
    case (state)
      ST_BIT_LO, ST_BIT_HI: tmr_last_c = shreg[BYTE_W-1] ? CNT_W'(HALF_ONE - 1)
                                                         : CNT_W'(HALF_ZERO - 1);
`ifdef TAPE_PILOT_EN
      ST_PILOT:             tmr_last_c = CNT_W'(PILOT_HALF - 1);
      ST_SYNC:              tmr_last_c = CNT_W'(SYNC_HALF - 1);
`endif
      default:              tmr_last_c = '0;
    endcase
  end

  // Next-state, datapath and registered-output decode.
  always_comb begin
    state_nxt     = state;
    byte_idx_nxt  = byte_idx;
    shreg_nxt     = shreg;
    orig_nxt      = orig_q;
    bit_cnt_nxt   = bit_cnt;
    progress_nxt  = progress;
    ear_nxt       = ear;
    src_addr_nxt  = src_addr;
    wr_addr_nxt   = wr_addr;
    wr_data_nxt   = wr_data;
    wr_en_nxt     = 1'b0;
    busy_nxt      = 1'b0;
    done_nxt      = 1'b0;
    border_nxt    = BORDER_IDLE;
    tmr_clr_c     = 1'b0;
`ifdef TAPE_PILOT_EN
    pilot_cnt_nxt = pilot_cnt;
`endif

    case (state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_nxt     = FIRST_ST;
          progress_nxt  = '0;
          byte_idx_nxt  = '0;
          ear_nxt       = 1'b0;
`ifdef TAPE_PILOT_EN
          pilot_cnt_nxt = '0;
`endif
        end
      end
`ifdef TAPE_PILOT_EN
      ST_PILOT: begin
        if (tmr_tc_c) begin
          if (pilot_cnt == PCNT_W'(PILOT_PULSES - 1)) begin
            state_nxt     = ST_SYNC;
            pilot_cnt_nxt = '0;
            ear_nxt       = 1'b0;
          end else begin
            pilot_cnt_nxt = pilot_cnt + PCNT_W'(1);
            ear_nxt       = ~ear;
          end
        end
      end
      ST_SYNC: begin
        if (tmr_tc_c) begin
          if (ear) begin
            state_nxt = ST_FETCH;
          end else begin
            ear_nxt = 1'b1;
          end
        end
      end
`endif
      ST_FETCH: begin
        state_nxt = ST_LATCH;
      end
      ST_LATCH: begin
        shreg_nxt   = src_data;
        orig_nxt    = src_data;
        bit_cnt_nxt = BITC_W'(7);
        state_nxt   = ST_BIT_LO;
      end
      ST_BIT_LO: begin
        if (tmr_tc_c) begin
          state_nxt = ST_BIT_HI;
        end
      end
      ST_BIT_HI: begin
        if (tmr_tc_c) begin
          shreg_nxt = {shreg[BYTE_W-2:0], 1'b0};
          if (bit_cnt == '0) begin
            state_nxt = ST_WRITE;
          end else begin
            bit_cnt_nxt = bit_cnt - BITC_W'(1);
            state_nxt   = ST_BIT_LO;
          end
        end
      end
      ST_WRITE: begin
        byte_idx_nxt = byte_idx + ADDR_W'(1);
        progress_nxt = byte_idx_nxt;
        if (byte_idx_nxt == ADDR_W'(NUM_BYTES)) begin
          state_nxt = ST_DONE;
        end else begin
          state_nxt = ST_FETCH;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase

    // Skip abandons any partial byte and reports the whole image as loaded.
    if (skip) begin
      state_nxt    = ST_DONE;
      progress_nxt = ADDR_W'(NUM_BYTES);
    end

    wr_en_nxt = (state_nxt == ST_WRITE);
    busy_nxt  = (state_nxt != ST_IDLE) && (state_nxt != ST_DONE);
    done_nxt  = (state_nxt == ST_DONE);
    tmr_clr_c = (state_nxt != state);

    if (wr_en_nxt) begin
      wr_addr_nxt = byte_idx;
      wr_data_nxt = orig_q;
    end
    if (state_nxt == ST_FETCH) begin
      src_addr_nxt = byte_idx_nxt;
    end

    case (state_nxt)
      ST_PILOT, ST_SYNC: begin
        border_nxt = ear_nxt ? BORDER_PILOT_HI : BORDER_PILOT_LO;
      end
      ST_BIT_HI: begin
        ear_nxt    = 1'b1;
        border_nxt = BORDER_BIT_HI;
      end
      ST_FETCH, ST_LATCH, ST_BIT_LO, ST_WRITE: begin
        ear_nxt    = 1'b0;
        border_nxt = BORDER_BIT_LO;
      end
      default: begin
        ear_nxt    = 1'b0;
        border_nxt = BORDER_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      byte_idx  <= '0;
      shreg     <= '0;
      orig_q    <= '0;
      bit_cnt   <= '0;
`ifdef TAPE_PILOT_EN
      pilot_cnt <= '0;
`endif
      src_addr  <= '0;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      progress  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      ear       <= 1'b0;
      border    <= BORDER_IDLE;
    end else begin
      state     <= state_nxt;
      byte_idx  <= byte_idx_nxt;
      shreg     <= shreg_nxt;
      orig_q    <= orig_nxt;
      bit_cnt   <= bit_cnt_nxt;
`ifdef TAPE_PILOT_EN
      pilot_cnt <= pilot_cnt_nxt;
`endif
      src_addr  <= src_addr_nxt;
      wr_en     <= wr_en_nxt;
      wr_addr   <= wr_addr_nxt;
      wr_data   <= wr_data_nxt;
      progress  <= progress_nxt;
      busy      <= busy_nxt;
      done      <= done_nxt;
      ear       <= ear_nxt;
      border    <= border_nxt;
    end
  end

endmodule
